// File: rtl/karatsuba_ctrl.sv
// karatsuba_ctrl: sequential Karatsuba multiplier. One shared (H+1)x(H+1)
// sub-multiplier is time-shared over three cycles to form z0, z2 and the
// middle product; a final cycle combines them into the 2*WIDTH-bit result.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; operands latched on the accepting edge
// MUL_LO    | z0 <= Xl*Yl
// MUL_HI    | z2 <= Xh*Yh
// MUL_MID   | zm <= (Xl+Xh)*(Yl+Yh)
// COMBINE   | Z <= z2<<WIDTH + (zm-z2-z0)<<H + z0; pulse done
module karatsuba_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * H + 2;
    localparam int ZW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_LO,
        S_MUL_HI,
        S_MUL_MID,
        S_COMBINE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_xr;
    logic [WIDTH-1:0]   r_yr;
    logic [PW-1:0]      r_z0;
    logic [PW-1:0]      r_z2;
    logic [PW-1:0]      r_zm;
    logic               r_busy;
    logic               r_done;
    logic [ZW-1:0]      r_z;

    logic [H:0]         w_xs;
    logic [H:0]         w_ys;
    logic [H:0]         w_op_a;
    logic [H:0]         w_op_b;
    logic [PW-1:0]      w_prod;
    logic [PW-1:0]      w_z1;
    logic [ZW-1:0]      w_result;

    assign w_xs = {1'b0, r_xr[H-1:0]} + {1'b0, r_xr[WIDTH-1:H]};
    assign w_ys = {1'b0, r_yr[H-1:0]} + {1'b0, r_yr[WIDTH-1:H]};

    // Operand mux for the single shared sub-multiplier, steered by state.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_MUL_LO: begin
                w_op_a = {1'b0, r_xr[H-1:0]};
                w_op_b = {1'b0, r_yr[H-1:0]};
            end
            S_MUL_HI: begin
                w_op_a = {1'b0, r_xr[WIDTH-1:H]};
                w_op_b = {1'b0, r_yr[WIDTH-1:H]};
            end
            S_MUL_MID: begin
                w_op_a = w_xs;
                w_op_b = w_ys;
            end
            default: begin
                w_op_a = '0;
                w_op_b = '0;
            end
        endcase
    end

    assign w_prod = {{(H + 1){1'b0}}, w_op_a} * {{(H + 1){1'b0}}, w_op_b};

    // Middle term is never negative since zm = z0 + z1 + z2 by construction.
    assign w_z1 = r_zm - r_z2 - r_z0;

    assign w_result = ({{(ZW - PW){1'b0}}, r_z2} << WIDTH)
                    + ({{(ZW - PW){1'b0}}, w_z1} << H)
                    + {{(ZW - PW){1'b0}}, r_z0};

    // Sequencer: operand capture, partial-product registers, result and handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_xr    <= '0;
            r_yr    <= '0;
            r_z0    <= '0;
            r_z2    <= '0;
            r_zm    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xr    <= X;
                        r_yr    <= Y;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL_LO;
                    end
                end
                S_MUL_LO: begin
                    r_z0    <= w_prod;
                    r_state <= S_MUL_HI;
                end
                S_MUL_HI: begin
                    r_z2    <= w_prod;
                    r_state <= S_MUL_MID;
                end
                S_MUL_MID: begin
                    r_zm    <= w_prod;
                    r_state <= S_COMBINE;
                end
                S_COMBINE: begin
                    r_z     <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Z    = r_z;

endmodule

// File: tb/tb_karatsuba_ctrl.sv
// Scoreboard bench for karatsuba_ctrl: expected products are queued when a
// request is driven and compared whenever done pulses.
module tb_karatsuba_ctrl;

    localparam int W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [W-1:0]     X;
    logic [W-1:0]     Y;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   Z;

    int               n_vec;
    int               n_err;
    int               n_done;
    int               cyc;
    int               done_cyc [$];
    logic [2*W-1:0]   exp_q [$];
    logic [2*W-1:0]   last_z;

    karatsuba_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: compare output against scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                n_done++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    last_z = exp_q.pop_front();
                    check("Z", {16'd0, Z}, {16'd0, last_z});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check busy after accept and done latency of 4 edges.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        start = 1'b1;
        X     = x;
        Y     = y;
        exp_q.push_back(16'(x) * 16'(y));
        tick();
        start = 1'b0;
        X     = W'($urandom);
        Y     = W'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            lat = i;
            if (done === 1'b1) break;
            if (i == 8) lat = 9;
        end
        check("latency", lat, 32'd4);
    endtask

    initial begin
        logic [W-1:0] vx [6];
        logic [W-1:0] vy [6];
        int d0;
        n_vec  = 0;
        n_err  = 0;
        n_done = 0;
        cyc    = 0;
        reset  = 1'b0;
        start  = 1'b0;
        X      = '0;
        Y      = '0;

        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_Z", {16'd0, Z}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_Z", {16'd0, Z}, 32'd0);
        end

        run_op(8'd16, 8'd16);
        repeat (10) tick();
        check("Z_hold", {16'd0, Z}, 32'd256);
        check("done_cleared", {31'd0, done}, 32'd0);

        vx = '{8'd255, 8'h0F, 8'd0, 8'd1, 8'd128, 8'd170};
        vy = '{8'd255, 8'hF0, 8'd200, 8'd255, 8'd2, 8'd85};
        for (int i = 0; i < 6; i++) begin
            run_op(vx[i], vy[i]);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom));
            tick();
        end

        // start while busy must be ignored
        d0 = n_done;
        start = 1'b1; X = 8'd3; Y = 8'd5;
        exp_q.push_back(16'd15);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; X = 8'd7; Y = 8'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("busy_start_dones", n_done - d0, 32'd1);
        check("busy_start_Z", {16'd0, Z}, 32'd15);

        // back-to-back with start held high
        d0 = done_cyc.size();
        start = 1'b1; X = 8'd12; Y = 8'd13;
        exp_q.push_back(16'd156);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) break;
        end
        X = 8'd200; Y = 8'd100;
        exp_q.push_back(16'd20000);
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("b2b_dones", done_cyc.size() - d0, 32'd2);
        if (done_cyc.size() - d0 == 2)
            check("b2b_spacing", done_cyc[d0+1] - done_cyc[d0], 32'd5);
        check("b2b_Z", {16'd0, Z}, 32'd20000);

        // reset mid-operation
        d0 = n_done;
        start = 1'b1; X = 8'd100; Y = 8'd100;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_Z", {16'd0, Z}, 32'd0);
        reset = 1'b1;
        repeat (8) tick();
        check("abort_no_done", n_done - d0, 32'd0);
        run_op(8'd100, 8'd100);
        tick();
        check("reissue_Z", {16'd0, Z}, 32'd10000);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
